// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
`default_nettype none

package regarb_pkg;

    localparam int              REG_AW   = 5;
    localparam logic [REG_AW-1:0] XZR_ADDR = 5'd31;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // Per-slot occupancy state; the v field of slot_t carries it.
    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_BUSY  = 1'b1;

    typedef struct packed {
        logic       v;
        logic [2:0] id;
    } slot_t;

endpackage

`default_nettype wire

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PW-1:0]      idx_o,
    output logic               any_o
);

    logic [PW:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Explicit wrap: NUM_REQ need not be a power of two.
            cand = {1'b0, ptr_i} + (PW+1)'(off);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!any_o && req_i[cand[PW-1:0]]) begin
                any_o                 = 1'b1;
                grant_o[cand[PW-1:0]] = 1'b1;
                idx_o                 = cand[PW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of one register-file read port with a fixed 2-cycle response.
// Build option REGARB_XZR_EN: reads of register 31 return zero and do not move mux_sel.
`default_nettype none

module regfile_read_arbiter
    import regarb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int AW      = REG_AW
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [AW-1:0]         mux_sel,
    input  logic [DATA_W-1:0]     mux_rdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]     rsp_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] arb_req, gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [AW-1:0]      gnt_addr;
    logic               gnt_is_xzr;
    logic               s1_is_xzr;
    slot_t              s1_q, s1_d;
    logic [AW-1:0]      mux_sel_q, mux_sel_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    // Masking the requests (not the grant) keeps reset and flush free of any grant.
    assign arb_req = (reset_n && !flush) ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arbiter (
        .req_i   (arb_req),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_addr = req_addr[i*AW +: AW];
            end
        end
    end

`ifdef REGARB_XZR_EN
    logic s1_xzr_q;

    assign gnt_is_xzr = (gnt_addr == AW'(XZR_ADDR));
    assign s1_is_xzr  = s1_xzr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_xzr_q <= 1'b0;
        end else begin
            s1_xzr_q <= gnt_any && gnt_is_xzr;
        end
    end
`else
    assign gnt_is_xzr = 1'b0;
    assign s1_is_xzr  = 1'b0;
`endif

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end

        s1_d.v  = gnt_any ? SLOT_BUSY : SLOT_EMPTY;
        s1_d.id = 3'(gnt_idx);

        mux_sel_d = mux_sel_q;
        if (gnt_any && !gnt_is_xzr) begin
            mux_sel_d = gnt_addr;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = (s1_q.v == SLOT_BUSY) && !flush && (s1_q.id == 3'(i));
        end

        rsp_data_d = rsp_data_q;
        if (s1_q.v == SLOT_BUSY) begin
            rsp_data_d = s1_is_xzr ? '0 : mux_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            s1_q        <= '{v: SLOT_EMPTY, id: 3'd0};
            mux_sel_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_q        <= s1_d;
            mux_sel_q   <= mux_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = gnt;
    assign mux_sel   = mux_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
// Directed scenarios followed by random traffic, checked against a queue-based model.
`default_nettype none

module tb_regfile_read_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 5;
`ifdef REGARB_XZR_EN
    localparam bit XZR_EN = 1'b1;
`else
    localparam bit XZR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   mux_sel;
    logic [DW-1:0]   mux_rdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    logic [DW-1:0] bank [32];
    assign mux_rdata = bank[mux_sel];

    always #5 clk = ~clk;

    regfile_read_arbiter #(.NUM_REQ(N), .DATA_W(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .mux_rdata (mux_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } ent_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            mptr   = 0;
    int            last_grant = -1;
    logic [AW-1:0] addr [N];
    logic [AW-1:0] exp_mux = '0;
    logic [N-1:0]  exp_rv  = '0;
    logic [DW-1:0] exp_rd  = '0;
    bit            chk_rd  = 1'b0;
    logic [N-1:0]  obs_ready;
    ent_t          pend [$];
    int            seq [5];

    function automatic int model_grant();
        if (reset_n !== 1'b1 || flush) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit is_xzr(input logic [AW-1:0] a);
        return XZR_EN && (a == 5'd31);
    endfunction

    // One clock: check the grant before the edge, advance the model, check registered outputs.
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        ent_t         e;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        obs_ready = req_ready;
        checks++;
        assert (req_ready === exp_rdy) else begin
            errors++;
            $error("FAIL req_ready cyc=%0d observed=%b expected=%b", cyc, req_ready, exp_rdy);
        end
        last_grant = g;
        @(posedge clk);
        #1;
        cyc++;
        if (reset_n !== 1'b1) begin
            pend.delete();
            mptr = 0; exp_mux = '0; exp_rv = '0; exp_rd = '0; chk_rd = 1'b1;
        end else if (flush) begin
            pend.delete();
            exp_rv = '0; chk_rd = 1'b0;
        end else begin
            exp_rv = '0; chk_rd = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                exp_rv[e.id] = 1'b1;
                exp_rd = e.data;
                chk_rd = 1'b1;
            end
            if (g >= 0) begin
                e.due  = cyc + 1;
                e.id   = g;
                e.data = is_xzr(addr[g]) ? '0 : bank[addr[g]];
                pend.push_back(e);
                mptr = (g + 1) % N;
                if (!is_xzr(addr[g])) exp_mux = addr[g];
            end
        end
        checks++;
        assert (rsp_valid === exp_rv) else begin
            errors++;
            $error("FAIL rsp_valid cyc=%0d observed=%b expected=%b", cyc, rsp_valid, exp_rv);
        end
        checks++;
        assert (mux_sel === exp_mux) else begin
            errors++;
            $error("FAIL mux_sel cyc=%0d observed=%0d expected=%0d", cyc, mux_sel, exp_mux);
        end
        if (chk_rd) begin
            checks++;
            assert (rsp_data === exp_rd) else begin
                errors++;
                $error("FAIL rsp_data cyc=%0d observed=%h expected=%h", cyc, rsp_data, exp_rd);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = {$urandom, $urandom};
        bank[5]  = 64'hDEAD_BEEF;
        bank[31] = '1;
        for (int i = 0; i < N; i++) addr[i] = AW'($urandom_range(0, 31));

        // Reset held two cycles with every requester asking
        reset_n = 1'b0; flush = 1'b0; req_valid = '1;
        cycle(); cycle();
        reset_n = 1'b1; req_valid = '0;
        cycle();

        // Single read of X5
        req_valid = 4'b0001; addr[0] = 5'd5;
        cycle();
        checks++;
        assert (obs_ready === 4'b0001) else begin
            errors++; $error("FAIL single_ready observed=%b expected=0001", obs_ready);
        end
        checks++;
        assert (mux_sel === 5'd5) else begin
            errors++; $error("FAIL single_sel observed=%0d expected=5", mux_sel);
        end
        req_valid = '0;
        cycle();
        checks++;
        assert (rsp_valid === 4'b0001 && rsp_data === 64'hDEAD_BEEF) else begin
            errors++; $error("FAIL single_rsp observed=%b/%h expected=0001/deadbeef", rsp_valid, rsp_data);
        end
        cycle();

        // All four requesting continuously from rr_ptr=0
        reset_n = 1'b0; cycle();
        reset_n = 1'b1; req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            seq[k] = -1;
            for (int i = 0; i < N; i++) if (obs_ready === (4'b0001 << i)) seq[k] = i;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            assert (seq[k] == k % N) else begin
                errors++; $error("FAIL rr_order step=%0d observed=%0d expected=%0d", k, seq[k], k % N);
            end
        end
        req_valid = '0;
        cycle(); cycle();

        // Grant req2, flush on the following cycle with everyone requesting
        req_valid = 4'b0100; addr[2] = 5'd9;
        cycle();
        flush = 1'b1; req_valid = '1;
        cycle();
        checks++;
        assert (obs_ready === 4'b0000 && rsp_valid === 4'b0000) else begin
            errors++; $error("FAIL flush observed=%b/%b expected=0000/0000", obs_ready, rsp_valid);
        end
        flush = 1'b0; req_valid = '0;
        cycle(); cycle();

        // XZR read
        req_valid = 4'b0010; addr[1] = 5'd31;
        cycle();
        req_valid = '0;
        cycle();
        checks++;
        assert (rsp_valid === 4'b0010 && rsp_data === (XZR_EN ? 64'd0 : {DW{1'b1}})) else begin
            errors++; $error("FAIL xzr observed=%b/%h expected=0010/%h", rsp_valid, rsp_data,
                             XZR_EN ? 64'd0 : {DW{1'b1}});
        end
        cycle();

        // Reset while a read is in flight
        req_valid = 4'b1000; addr[3] = 5'd7;
        cycle();
        reset_n = 1'b0; req_valid = '0;
        cycle();
        reset_n = 1'b1;
        cycle();
        checks++;
        assert (rsp_valid === 4'b0000) else begin
            errors++; $error("FAIL reset_drop observed=%b expected=0000", rsp_valid);
        end
        req_valid = '1;
        cycle();
        checks++;
        assert (obs_ready === 4'b0001) else begin
            errors++; $error("FAIL reset_ptr observed=%b expected=0001", obs_ready);
        end

        // Random traffic with occasional flush and reset
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    addr[i]      = AW'($urandom_range(0, 31));
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            flush   = ($urandom_range(0, 15) == 0);
            reset_n = ($urandom_range(0, 49) != 0);
            cycle();
        end

        reset_n = 1'b1; flush = 1'b0; req_valid = '0;
        cycle(); cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
